pong_game_ctrl: RTL

Game-state controller for the pong datapath: owns ball position, direction and both scores, and sequences one physics update per video frame. It consumes the debounced paddle positions and a once-per-frame tick from the VGA timing block, and drives ball coordinates and scores to the pixel renderer. It runs serve, rally, point and game-over, so the top level only has to draw.

---
 rtl/pong_pkg.sv | 40 ++++
 rtl/pong_game_ctrl_if.sv | 28 ++
 rtl/pong_frame_timer.sv | 37 +++
 rtl/pong_game_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state enum, geometry defaults and centre constants for pong_game_ctrl
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_UPD_MOVE,
        ST_UPD_WALL,
        ST_UPD_PADDLE,
        ST_UPD_SCORE,
        ST_GAME_OVER
    } pong_state_e;

    localparam int PADDLE_WIDTH_DEF = 8;
    localparam int H_RES_DEF        = 640;
    localparam int V_RES_DEF        = 480;
    localparam int BALL_SIZE_DEF    = 8;
    localparam int BALL_SPEED_DEF   = 2;
    localparam int PADDLE_H_DEF     = 64;
    localparam int PADDLE_W_DEF     = 8;
    localparam int PADDLE_X1_DEF    = 16;
    localparam int PADDLE_X2_DEF    = 616;
    localparam int WIN_SCORE_DEF    = 9;
    localparam int SERVE_FRAMES_DEF = 60;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // Top-left coordinate that centres the ball on an axis of length res.
    function automatic logic [9:0] centre_coord(input int res, input int size);
        return 10'((res - size) / 2);
    endfunction

    localparam logic [9:0] CENTRE_X = centre_coord(H_RES_DEF, BALL_SIZE_DEF);
    localparam logic [9:0] CENTRE_Y = centre_coord(V_RES_DEF, BALL_SIZE_DEF);

endpackage

// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - frame/paddle inputs and ball/score outputs of the game controller
// master: video/timing side (drives frame_tick, start, paddles)
// slave : game controller (drives ball_x/ball_y, scores, point, busy, game_over)
interface pong_game_ctrl_if #(
    parameter int PADDLE_WIDTH = pong_pkg::PADDLE_WIDTH_DEF
);
    logic                    frame_tick;
    logic                    start;
    logic [PADDLE_WIDTH-1:0] paddle1;
    logic [PADDLE_WIDTH-1:0] paddle2;
    logic [9:0]              ball_x;
    logic [9:0]              ball_y;
    logic [3:0]              score1;
    logic [3:0]              score2;
    logic                    point;
    logic                    busy;
    logic                    game_over;

    modport master (
        output frame_tick, start, paddle1, paddle2,
        input  ball_x, ball_y, score1, score2, point, busy, game_over
    );

    modport slave (
        input  frame_tick, start, paddle1, paddle2,
        output ball_x, ball_y, score1, score2, point, busy, game_over
    );
endinterface

// File: rtl/pong_frame_timer.sv
// rtl/pong_frame_timer.sv - loadable frame down-counter flagging zero, used for the serve delay
// clk, reset   : clock, asynchronous active-high reset
// load_i       : load load_val_i (has priority over tick_i)
// tick_i       : decrement by one, stops at zero
// zero_o       : count is zero
module pong_frame_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             tick_i,
    output logic             zero_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game-state controller: serve, per-frame physics update, scoring
// clk, reset : clock, asynchronous active-high reset
// bus        : pong_game_ctrl_if.slave (frame_tick/start/paddles in; ball, scores, point, busy, game_over out)
// PONG_SPEEDUP_EN : when defined, each paddle hit raises speed by 1 up to 2*BALL_SPEED
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int PADDLE_WIDTH = PADDLE_WIDTH_DEF,
    parameter int H_RES        = H_RES_DEF,
    parameter int V_RES        = V_RES_DEF,
    parameter int BALL_SIZE    = BALL_SIZE_DEF,
    parameter int BALL_SPEED   = BALL_SPEED_DEF,
    parameter int PADDLE_H     = PADDLE_H_DEF,
    parameter int PADDLE_W     = PADDLE_W_DEF,
    parameter int PADDLE_X1    = PADDLE_X1_DEF,
    parameter int PADDLE_X2    = PADDLE_X2_DEF,
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    pong_game_ctrl_if.slave bus
);
    localparam logic [9:0] CX = centre_coord(H_RES, BALL_SIZE);
    localparam logic [9:0] CY = centre_coord(V_RES, BALL_SIZE);

    localparam logic signed [10:0] X_MAX    = 11'(H_RES - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX    = 11'(V_RES - BALL_SIZE);
    localparam logic signed [10:0] TOP_MAX  = 11'(V_RES - PADDLE_H);
    localparam logic signed [10:0] BS       = 11'(BALL_SIZE);
    localparam logic signed [10:0] PH       = 11'(PADDLE_H);
    localparam logic signed [10:0] PX1      = 11'(PADDLE_X1);
    localparam logic signed [10:0] PX1_EDGE = 11'(PADDLE_X1 + PADDLE_W);
    localparam logic signed [10:0] PX2      = 11'(PADDLE_X2);
    localparam logic signed [10:0] PX2_EDGE = 11'(PADDLE_X2 + PADDLE_W);
    localparam logic signed [10:0] PX2_STOP = 11'(PADDLE_X2 - BALL_SIZE);

    localparam logic [3:0] SPEED_BASE = 4'(BALL_SPEED);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);
    localparam int         TW         = $clog2(SERVE_FRAMES + 1);

    pong_state_e       state_q, state_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic signed [10:0] nx_q, nx_d, ny_q, ny_d;
    logic              dx_q, dx_d, dy_q, dy_d;
    logic              serve_dy_q, serve_dy_d;
    logic [3:0]        score1_q, score1_d, score2_q, score2_d;
    logic              point_q, point_d;
    logic              tmr_load;
    logic              tmr_zero;
    logic [3:0]        speed_q;

    pong_frame_timer #(.WIDTH(TW)) u_serve_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (TW'(SERVE_FRAMES)),
        .tick_i     (bus.frame_tick && (state_q == ST_SERVE)),
        .zero_o     (tmr_zero)
    );

    // Paddle top = min(position*2, V_RES-PADDLE_H).
    logic signed [10:0] p1_sh, p2_sh, top1, top2;
    assign p1_sh = signed'(11'({bus.paddle1, 1'b0}));
    assign p2_sh = signed'(11'({bus.paddle2, 1'b0}));
    assign top1  = (p1_sh > TOP_MAX) ? TOP_MAX : p1_sh;
    assign top2  = (p2_sh > TOP_MAX) ? TOP_MAX : p2_sh;

    // Hit tests evaluated on the post-wall candidate position.
    logic hit1, hit2;
    assign hit1 = (dx_q == DIR_LEFT) && (nx_q <= PX1_EDGE) && (nx_q + BS > PX1)
               && (ny_q < top1 + PH) && (ny_q + BS > top1);
    assign hit2 = (dx_q == DIR_RIGHT) && (nx_q + BS >= PX2) && (nx_q < PX2_EDGE)
               && (ny_q < top2 + PH) && (ny_q + BS > top2);

`ifdef PONG_SPEEDUP_EN
    localparam logic [3:0] SPEED_MAX = 4'(2 * BALL_SPEED);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed_q <= SPEED_BASE;
        end else if ((state_q == ST_SERVE) && tmr_zero) begin
            speed_q <= SPEED_BASE;
        end else if ((state_q == ST_UPD_PADDLE) && (hit1 || hit2) && (speed_q < SPEED_MAX)) begin
            speed_q <= speed_q + 4'd1;
        end
    end
`else
    assign speed_q = SPEED_BASE;
`endif

    logic signed [10:0] cur_x, cur_y, spd;
    assign cur_x = signed'({1'b0, x_q});
    assign cur_y = signed'({1'b0, y_q});
    assign spd   = signed'({7'd0, speed_q});

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        nx_d       = nx_q;
        ny_d       = ny_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        serve_dy_d = serve_dy_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        point_d    = 1'b0;
        tmr_load   = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                x_d = CX;
                y_d = CY;
                if (bus.start) begin
                    state_d    = ST_SERVE;
                    tmr_load   = 1'b1;
                    score1_d   = '0;
                    score2_d   = '0;
                    dx_d       = DIR_RIGHT;
                    dy_d       = DIR_DOWN;
                    serve_dy_d = DIR_DOWN;
                end
            end
            ST_SERVE: begin
                x_d = CX;
                y_d = CY;
                if (tmr_zero) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.frame_tick) state_d = ST_UPD_MOVE;
            end
            ST_UPD_MOVE: begin
                nx_d    = (dx_q == DIR_RIGHT) ? cur_x + spd : cur_x - spd;
                ny_d    = (dy_q == DIR_DOWN)  ? cur_y + spd : cur_y - spd;
                state_d = ST_UPD_WALL;
            end
            ST_UPD_WALL: begin
                if (ny_q <= 11'sd0) begin
                    ny_d = '0;
                    dy_d = DIR_DOWN;
                end else if (ny_q >= Y_MAX) begin
                    ny_d = Y_MAX;
                    dy_d = DIR_UP;
                end
                state_d = ST_UPD_PADDLE;
            end
            ST_UPD_PADDLE: begin
                if (hit1) begin
                    nx_d = PX1_EDGE;
                    dx_d = DIR_RIGHT;
                end else if (hit2) begin
                    nx_d = PX2_STOP;
                    dx_d = DIR_LEFT;
                end
                state_d = ST_UPD_SCORE;
            end
            ST_UPD_SCORE: begin
                if ((nx_q <= 11'sd0) || (nx_q >= X_MAX)) begin
                    point_d = 1'b1;
                    x_d     = CX;
                    y_d     = CY;
                    // Next serve heads toward whoever conceded.
                    if (nx_q <= 11'sd0) begin
                        score2_d = score2_q + 4'd1;
                        dx_d     = DIR_LEFT;
                    end else begin
                        score1_d = score1_q + 4'd1;
                        dx_d     = DIR_RIGHT;
                    end
                    if ((score1_d == WIN) || (score2_d == WIN)) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d    = ST_SERVE;
                        tmr_load   = 1'b1;
                        serve_dy_d = ~serve_dy_q;
                        dy_d       = ~serve_dy_q;
                    end
                end else begin
                    x_d     = nx_q[9:0];
                    y_d     = ny_q[9:0];
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            x_q        <= CX;
            y_q        <= CY;
            nx_q       <= '0;
            ny_q       <= '0;
            dx_q       <= DIR_RIGHT;
            dy_q       <= DIR_DOWN;
            serve_dy_q <= DIR_DOWN;
            score1_q   <= '0;
            score2_q   <= '0;
            point_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            nx_q       <= nx_d;
            ny_q       <= ny_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            serve_dy_q <= serve_dy_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            point_q    <= point_d;
        end
    end

    assign bus.ball_x    = x_q;
    assign bus.ball_y    = y_q;
    assign bus.score1    = score1_q;
    assign bus.score2    = score2_q;
    assign bus.point     = point_q;
    assign bus.busy      = (state_q == ST_UPD_MOVE) || (state_q == ST_UPD_WALL)
                        || (state_q == ST_UPD_PADDLE) || (state_q == ST_UPD_SCORE);
    assign bus.game_over = (state_q == ST_GAME_OVER);
endmodule
